// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions the raw push-button lines for the lock controller. Each key is
// synchronised, debounced by a small per-key state machine and turned into a
// clean debounced level plus one-cycle press and release pulses. In exclusive
// mode the controller never sees two keys pressed at the same time.
//
// Parameters
//   N_KEYS           number of conditioned keys (bit 0 = highest priority)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 1)
//   ACTIVE_LOW       1: raw line reads 0 when pressed; 0: reads 1 when pressed
//   EXCLUSIVE        1: at most one key may be in the pressed condition
//
// Ports
//   clk           in   system clock
//   system_reset  in   asynchronous, active-high reset
//   key_raw       in   raw, asynchronous button lines
//   key_level     out  debounced level, 1 = pressed (registered)
//   key_press     out  one-cycle pulse on an accepted press (registered)
//   key_release   out  one-cycle pulse on an accepted release (registered)
//   busy          out  1 while any key FSM is away from IDLE (registered)
//
// Debug visibility: the per-key FSM state is held in state_q[] (type
// key_state_e) and the per-key counter in cnt_q[]; both are plain arrays so
// checkers can bind to them directly.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int EXCLUSIVE       = 1
) (
    input  logic              clk,
    input  logic              system_reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // BLOCKED_RELEASE is the release confirmation of a refused key: it shares
    // the timing of CONFIRM_RELEASE but ends in IDLE without a release pulse
    // and never counts as owning the key set.
    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_CONFIRM_PRESS   = 3'd1,
        ST_PRESSED         = 3'd2,
        ST_CONFIRM_RELEASE = 3'd3,
        ST_BLOCKED         = 3'd4,
        ST_BLOCKED_RELEASE = 3'd5
    } key_state_e;

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [N_KEYS-1:0] act_raw;      // raw line normalised to 1 = pressed
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] act;          // synchronised, normalised key

    key_state_e        state_q [N_KEYS];
    key_state_e        state_d [N_KEYS];
    logic [CNT_W-1:0]  cnt_q   [N_KEYS];
    logic [CNT_W-1:0]  cnt_d   [N_KEYS];

    logic [N_KEYS-1:0] done;         // key completes CONFIRM_PRESS this cycle
    logic [N_KEYS-1:0] owner;        // key is in PRESSED or CONFIRM_RELEASE
    logic [N_KEYS-1:0] grant;        // completion may become PRESSED

    logic [N_KEYS-1:0] key_level_q, key_level_d;
    logic [N_KEYS-1:0] key_press_q, key_press_d;
    logic [N_KEYS-1:0] key_release_q, key_release_d;
    logic              busy_q, busy_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // -------------------------------------------------------------------------
    // Input normalisation and two-flop synchroniser
    // -------------------------------------------------------------------------
    assign act_raw = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;
    assign act     = sync2_q;

    always_comb begin
        sync1_d = act_raw;
        sync2_d = sync1_q;
    end

    // -------------------------------------------------------------------------
    // Arbitration. A completing key is refused when another key already owns
    // the key set, or when a lower-index (higher-priority) key completes in
    // the very same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        done  = '0;
        owner = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            done[i]  = (state_q[i] == ST_CONFIRM_PRESS) && act[i] &&
                       (cnt_q[i] == CNT_LAST);
            owner[i] = (state_q[i] == ST_PRESSED) ||
                       (state_q[i] == ST_CONFIRM_RELEASE);
        end
    end

    always_comb begin
        grant = '1;
        if (EXCLUSIVE != 0) begin
            for (int i = 0; i < N_KEYS; i++) begin
                for (int j = 0; j < N_KEYS; j++) begin
                    if ((j != i) && owner[j]) begin
                        grant[i] = 1'b0;
                    end
                    if ((j < i) && done[j]) begin
                        grant[i] = 1'b0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state, counter, synchroniser and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            key_level_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            busy_q        <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            key_level_q   <= key_level_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
            busy_q        <= busy_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next state and counter
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_IDLE: begin
                    if (act[i]) begin
                        state_d[i] = ST_CONFIRM_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                ST_CONFIRM_PRESS: begin
                    if (!act[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = grant[i] ? ST_PRESSED : ST_BLOCKED;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                ST_PRESSED: begin
                    if (!act[i]) begin
                        state_d[i] = ST_CONFIRM_RELEASE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_CONFIRM_RELEASE: begin
                    if (act[i]) begin
                        state_d[i] = ST_PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                ST_BLOCKED: begin
                    if (!act[i]) begin
                        state_d[i] = ST_BLOCKED_RELEASE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_BLOCKED_RELEASE: begin
                    if (act[i]) begin
                        state_d[i] = ST_BLOCKED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 3: outputs, decoded from the transition about to be taken so
    // that the registered outputs line up with the new state.
    // -------------------------------------------------------------------------
    always_comb begin
        key_level_d   = '0;
        key_press_d   = '0;
        key_release_d = '0;
        busy_d        = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            key_level_d[i]   = (state_d[i] == ST_PRESSED) ||
                               (state_d[i] == ST_CONFIRM_RELEASE);
            key_press_d[i]   = (state_q[i] == ST_CONFIRM_PRESS) &&
                               (state_d[i] == ST_PRESSED);
            key_release_d[i] = (state_q[i] == ST_CONFIRM_RELEASE) &&
                               (state_d[i] == ST_IDLE);
            if (state_d[i] != ST_IDLE) begin
                busy_d = 1'b1;
            end
        end
    end

    assign key_level   = key_level_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign busy        = busy_q;

    // -------------------------------------------------------------------------
    // Embedded properties
    // -------------------------------------------------------------------------
    a_no_press_and_release : assert property (
        @(posedge clk) disable iff (system_reset)
        (key_press_q & key_release_q) == '0
    );

    a_exclusive_level : assert property (
        @(posedge clk) disable iff (system_reset)
        (EXCLUSIVE == 0) || $onehot0(key_level_q)
    );

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner (N_KEYS=3, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1, EXCLUSIVE=1). Stimulus is applied on falling edges. Each
// expected press/release pulse is pushed as {edge, kind, key} into exp_q when
// the stimulus is issued; a monitor on the falling edge pops and compares on
// every pulse the DUT presents. Levels, busy and reset behaviour are checked
// directly from the stimulus thread.
//
// Timing: a key changed at a falling edge when edge_n == E is first sampled by
// edge E+1 (edge 0); the pulse appears after edge E+1+6, i.e. it is seen at the
// falling edge where edge_n == E + LAT.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int LAT = D + 3;
  localparam int EW  = 19;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         system_reset = 1'b0;
  logic [N-1:0] key_raw = '1;
  logic [N-1:0] key_level;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic         busy;

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  key_conditioner #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1),
    .EXCLUSIVE       (1)
  ) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .key_raw      (key_raw),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .busy         (busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual === required) n_pass++;
    else $display("FAIL %s: got %0h required %0h (edge %0d)", name, actual, required, edge_n);
  endtask

  function automatic logic [EW-1:0] evt(input int e, input bit rel, input int k);
    logic [15:0] e16;
    logic [1:0]  k2;
    e16 = e[15:0];
    k2  = k[1:0];
    return {e16, rel, k2};
  endfunction

  task automatic got_event(input logic [EW-1:0] got);
    logic [EW-1:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_pulse: got edge=%0d rel=%0d key=%0d required none",
               got[EW-1:3], got[2], got[1:0]);
    end else begin
      want = exp_q.pop_front();
      check("pulse", got, want);
    end
  endtask

  // Monitor: every pulse the DUT presents is checked against the queue.
  always @(negedge clk) begin
    if (!system_reset) begin
      for (int k = 0; k < N; k++) begin
        if (key_press[k])   got_event(evt(edge_n, 1'b0, k));
        if (key_release[k]) got_event(evt(edge_n, 1'b1, k));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k);
    key_raw[k] = 1'b0;
  endtask

  task automatic release_key(input int k);
    key_raw[k] = 1'b1;
  endtask

  task automatic expect_press(input int k);
    exp_q.push_back(evt(edge_n + LAT, 1'b0, k));
  endtask

  task automatic expect_release(input int k);
    exp_q.push_back(evt(edge_n + LAT, 1'b1, k));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {key_level, key_press, key_release, busy}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #1 system_reset = 1'b1;
    #1 check_all_zero("reset_state");
    wait_cyc(3);
    system_reset = 1'b0;
    wait_cyc(3);
    check_all_zero("idle_after_reset");

    // 1. Clean press and release of key 1
    press(1); expect_press(1);
    wait_cyc(6);
    check("t1_level_before", key_level[1], 0);
    wait_cyc(1);
    check("t1_level_on", key_level[1], 1);
    check("t1_busy", busy, 1);
    wait_cyc(13);
    release_key(1); expect_release(1);
    wait_cyc(6);
    check("t1_level_hold", key_level[1], 1);
    wait_cyc(1);
    check("t1_level_off", key_level[1], 0);
    wait_cyc(5);
    check("t1_busy_idle", busy, 0);

    // 2. Bounce: 3 low, 1 high, 10 low
    press(1);
    wait_cyc(3);
    release_key(1);
    wait_cyc(1);
    press(1); expect_press(1);
    wait_cyc(6);
    check("t2_level_before", key_level[1], 0);
    wait_cyc(4);
    check("t2_level_on", key_level[1], 1);
    release_key(1); expect_release(1);
    wait_cyc(12);
    check("t2_busy_idle", busy, 0);

    // 3. Release glitches of 2 and D-1 cycles while pressed
    press(1); expect_press(1);
    wait_cyc(10);
    release_key(1);
    wait_cyc(2);
    press(1);
    wait_cyc(2);
    check("t3_level_glitch2_mid", key_level[1], 1);
    wait_cyc(5);
    check("t3_level_glitch2_after", key_level[1], 1);
    release_key(1);
    wait_cyc(3);
    press(1);
    wait_cyc(8);
    check("t3_level_glitch3_after", key_level[1], 1);
    release_key(1); expect_release(1);
    wait_cyc(12);
    check("t3_level_off", key_level[1], 0);

    // 4. Exclusive hold: key 0 owns, key 2 pressed later is blocked
    press(0); expect_press(0);
    wait_cyc(10);
    press(2);
    wait_cyc(10);
    check("t4_level0", key_level[0], 1);
    check("t4_level2_blocked", key_level[2], 0);
    check("t4_busy", busy, 1);
    release_key(0); expect_release(0);
    wait_cyc(15);
    check("t4_level2_still_blocked", key_level[2], 0);
    check("t4_busy_blocked", busy, 1);
    release_key(2);
    wait_cyc(10);
    check("t4_busy_idle", busy, 0);
    press(2); expect_press(2);
    wait_cyc(15);
    check("t4_level2_repress", key_level[2], 1);
    release_key(2); expect_release(2);
    wait_cyc(10);

    // 5. Simultaneous press of keys 0 and 2: key 0 wins
    press(0); press(2); expect_press(0);
    wait_cyc(10);
    check("t5_level0", key_level[0], 1);
    check("t5_level2", key_level[2], 0);
    release_key(0); release_key(2); expect_release(0);
    wait_cyc(12);
    check("t5_busy_idle", busy, 0);

    // 6. Reset during CONFIRM_PRESS, then during PRESSED, key held throughout
    press(1);
    wait_cyc(3);
    check("t6_busy_confirm", busy, 1);
    #2 system_reset = 1'b1;
    #1 check_all_zero("t6_reset_confirm");
    wait_cyc(2);
    system_reset = 1'b0; expect_press(1);
    wait_cyc(6);
    check("t6_level_before", key_level[1], 0);
    wait_cyc(4);
    check("t6_level_pressed", key_level[1], 1);
    #2 system_reset = 1'b1;
    #1 check_all_zero("t6_reset_pressed");
    wait_cyc(2);
    system_reset = 1'b0; expect_press(1);
    wait_cyc(10);
    check("t6_level_again", key_level[1], 1);
    release_key(1); expect_release(1);
    wait_cyc(12);
    check_all_zero("t6_final_idle");

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
